// File: rtl/acp_avs_mc.sv
// Avalon-MM register block for a multi-channel DMA engine: ring bases/indices, attributes,
// per-channel cycle counters and producer-index interrupts; every access takes two cycles.
module acp_avs_mc #(
  parameter int C_NUM_CH = 2,
  parameter int C_IDX_W  = 16
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic [11:0]                       avs_address,
  input  logic                              avs_read,
  input  logic                              avs_write,
  input  logic [31:0]                       avs_writedata,
  output logic [31:0]                       avs_readdata,
  output logic                              avs_readdatavalid,
  output logic                              avs_waitrequest,
  output logic [C_NUM_CH*27-1:0]            hps2ip_base,
  output logic [C_NUM_CH*27-1:0]            hps2ip_ci_base,
  output logic [C_NUM_CH*27-1:0]            ip2hps_base,
  output logic [C_NUM_CH*27-1:0]            ip2hps_pi_base,
  output logic [C_NUM_CH*(C_IDX_W+1)-1:0]   hps2ip_mindex,
  output logic [C_NUM_CH*(C_IDX_W+1)-1:0]   ip2hps_mindex,
  output logic [C_NUM_CH*C_IDX_W-1:0]       hps2ip_pi,
  output logic [C_NUM_CH*C_IDX_W-1:0]       ip2hps_ci,
  input  logic [C_NUM_CH*C_IDX_W-1:0]       hps2ip_ci,
  input  logic [C_NUM_CH*C_IDX_W-1:0]       ip2hps_pi,
  output logic [C_NUM_CH-1:0]               dma_en,
  output logic [C_NUM_CH*12-1:0]            c_aw_attr,
  output logic [C_NUM_CH*12-1:0]            c_ar_attr,
  output logic                              irq
);

  logic                r_busy, r_rdv, r_irq;
  logic [31:0]         r_rdata, w_rdata;
  logic [26:0]         r_h2i_base [C_NUM_CH];
  logic [26:0]         r_h2i_cib  [C_NUM_CH];
  logic [26:0]         r_i2h_base [C_NUM_CH];
  logic [26:0]         r_i2h_pib  [C_NUM_CH];
  logic [C_IDX_W:0]    r_h2i_mi   [C_NUM_CH];
  logic [C_IDX_W:0]    r_i2h_mi   [C_NUM_CH];
  logic [C_IDX_W-1:0]  r_h2i_pi   [C_NUM_CH];
  logic [C_IDX_W-1:0]  r_i2h_ci   [C_NUM_CH];
  logic [C_IDX_W-1:0]  r_pi_q     [C_NUM_CH];
  logic [11:0]         r_aw_attr  [C_NUM_CH];
  logic [11:0]         r_ar_attr  [C_NUM_CH];
  logic [31:0]         r_cycle    [C_NUM_CH];
  logic [C_NUM_CH-1:0] r_dma_en, r_irq_en, r_status, r_mask, w_set, w_w1c;

  logic       w_req, w_acc, w_wr, w_rd, w_glb;
  logic [3:0] w_ch, w_reg;
  logic       w_unused;

  assign w_ch     = avs_address[9:6];
  assign w_reg    = avs_address[5:2];
  assign w_glb    = (w_ch == 4'hF);
  assign w_unused = ^{avs_address[11:10], avs_address[1:0]};

  // First cycle of a request stalls; the following cycle is the accept cycle.
  assign w_req           = avs_read | avs_write;
  assign avs_waitrequest = w_req & ~r_busy;
  assign w_acc           = w_req & r_busy;
  assign w_wr            = w_acc & avs_write;
  assign w_rd            = w_acc & avs_read & ~avs_write;
  assign w_w1c           = (w_wr && w_glb && w_reg == 4'h1) ? avs_writedata[C_NUM_CH-1:0] : '0;

  always_comb begin
    w_set = '0;
    for (int n = 0; n < C_NUM_CH; n++)
      w_set[n] = r_irq_en[n] && (ip2hps_pi[n*C_IDX_W +: C_IDX_W] != r_pi_q[n]);
  end

  always_comb begin
    w_rdata = '0;
    if (w_glb) begin
      case (w_reg)
        4'h0:    w_rdata = {16'hAC02, 8'h0, 8'(C_NUM_CH)};
        4'h1:    w_rdata = 32'(r_status);
        4'h2:    w_rdata = 32'(r_mask);
        default: w_rdata = '0;
      endcase
    end
    for (int n = 0; n < C_NUM_CH; n++) begin
      if (w_ch == 4'(n)) begin
        case (w_reg)
          4'h0:    w_rdata = {r_h2i_base[n], 5'h0};
          4'h1:    w_rdata = {r_h2i_cib[n], 5'h0};
          4'h2:    w_rdata = 32'(r_h2i_mi[n]);
          4'h3:    w_rdata = 32'(r_h2i_pi[n]);
          4'h4:    w_rdata = 32'(hps2ip_ci[n*C_IDX_W +: C_IDX_W]);
          4'h7:    w_rdata = r_cycle[n];
          4'h8:    w_rdata = {r_i2h_base[n], 5'h0};
          4'h9:    w_rdata = {r_i2h_pib[n], 5'h0};
          4'hA:    w_rdata = 32'(r_i2h_mi[n]);
          4'hB:    w_rdata = 32'(ip2hps_pi[n*C_IDX_W +: C_IDX_W]);
          4'hC:    w_rdata = 32'(r_i2h_ci[n]);
          4'hE:    w_rdata = {4'h0, r_ar_attr[n], 4'h0, r_aw_attr[n]};
          4'hF:    w_rdata = {30'h0, r_irq_en[n], r_dma_en[n]};
          default: w_rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_busy   <= 1'b0;
      r_rdv    <= 1'b0;
      r_rdata  <= '0;
      r_irq    <= 1'b0;
      r_status <= '0;
      r_mask   <= '0;
      r_dma_en <= '0;
      r_irq_en <= '0;
      for (int n = 0; n < C_NUM_CH; n++) begin
        r_h2i_base[n] <= '0;  r_h2i_cib[n] <= '0;
        r_i2h_base[n] <= '0;  r_i2h_pib[n] <= '0;
        r_h2i_mi[n]   <= '0;  r_i2h_mi[n]  <= '0;
        r_h2i_pi[n]   <= '0;  r_i2h_ci[n]  <= '0;
        r_pi_q[n]     <= '0;  r_cycle[n]   <= '0;
        r_aw_attr[n]  <= '0;  r_ar_attr[n] <= '0;
      end
    end else begin
      r_busy <= w_req & ~r_busy;
      r_rdv  <= w_rd;
      if (w_rd)
        r_rdata <= w_rdata;
      // A new set in the same cycle as its W1C keeps the bit asserted.
      r_status <= (r_status & ~w_w1c) | w_set;
      r_irq    <= |(r_status & r_mask);
      if (w_wr && w_glb && w_reg == 4'h2)
        r_mask <= avs_writedata[C_NUM_CH-1:0];
      for (int n = 0; n < C_NUM_CH; n++) begin
        r_pi_q[n]  <= ip2hps_pi[n*C_IDX_W +: C_IDX_W];
        r_cycle[n] <= r_dma_en[n] ? r_cycle[n] + 32'd1 : 32'd0;
        if (w_wr && w_ch == 4'(n)) begin
          case (w_reg)
            4'h0: r_h2i_base[n] <= avs_writedata[31:5];
            4'h1: r_h2i_cib[n]  <= avs_writedata[31:5];
            4'h2: r_h2i_mi[n]   <= avs_writedata[C_IDX_W:0];
            4'h3: r_h2i_pi[n]   <= avs_writedata[C_IDX_W-1:0];
            4'h8: r_i2h_base[n] <= avs_writedata[31:5];
            4'h9: r_i2h_pib[n]  <= avs_writedata[31:5];
            4'hA: r_i2h_mi[n]   <= avs_writedata[C_IDX_W:0];
            4'hC: r_i2h_ci[n]   <= avs_writedata[C_IDX_W-1:0];
            4'hE: begin
              r_aw_attr[n] <= avs_writedata[11:0];
              r_ar_attr[n] <= avs_writedata[27:16];
            end
            4'hF: begin
              r_dma_en[n] <= avs_writedata[0];
              r_irq_en[n] <= avs_writedata[1];
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign avs_readdata      = r_rdata;
  assign avs_readdatavalid = r_rdv;
  assign irq               = r_irq;
  assign dma_en            = r_dma_en;

  for (genvar g = 0; g < C_NUM_CH; g++) begin : g_ch
    assign hps2ip_base[g*27 +: 27]               = r_h2i_base[g];
    assign hps2ip_ci_base[g*27 +: 27]            = r_h2i_cib[g];
    assign ip2hps_base[g*27 +: 27]               = r_i2h_base[g];
    assign ip2hps_pi_base[g*27 +: 27]            = r_i2h_pib[g];
    assign hps2ip_mindex[g*(C_IDX_W+1) +: C_IDX_W+1] = r_h2i_mi[g];
    assign ip2hps_mindex[g*(C_IDX_W+1) +: C_IDX_W+1] = r_i2h_mi[g];
    assign hps2ip_pi[g*C_IDX_W +: C_IDX_W]       = r_h2i_pi[g];
    assign ip2hps_ci[g*C_IDX_W +: C_IDX_W]       = r_i2h_ci[g];
    assign c_aw_attr[g*12 +: 12]                 = r_aw_attr[g];
    assign c_ar_attr[g*12 +: 12]                 = r_ar_attr[g];
  end

endmodule

// File: doc/acp_avs_mc.md
ACP_AVS_MC -- requirements
Module: acp_avs_mc

Interface
REQ-001 C_NUM_CH, 2, number of DMA channels (1..8).
REQ-002 C_IDX_W, 16, ring index width (1..16); mindex is C_IDX_W+1 bits.
REQ-003 sys_clk  in  1  single clock; all logic on rising edge.
REQ-004 sys_rst  in  1  synchronous, active-high reset.
REQ-005 avs_address in 12, avs_read in 1, avs_write in 1, avs_writedata in 32: Avalon-MM slave request, byte address.
REQ-006 avs_readdata out 32, avs_readdatavalid out 1, avs_waitrequest out 1: Avalon-MM slave response.
REQ-007 hps2ip_base, hps2ip_ci_base, ip2hps_base, ip2hps_pi_base  out  C_NUM_CH*27  per-channel 32-byte-aligned addresses [31:5], channel n in bits [27n+26:27n].
REQ-008 hps2ip_mindex, ip2hps_mindex  out  C_NUM_CH*(C_IDX_W+1)  per-channel ring size mask.
REQ-009 hps2ip_pi, ip2hps_ci  out  C_NUM_CH*C_IDX_W  software-owned indices; hps2ip_ci, ip2hps_pi  in  C_NUM_CH*C_IDX_W  hardware-owned indices.
REQ-010 dma_en  out  C_NUM_CH  per-channel enable; c_aw_attr, c_ar_attr  out  C_NUM_CH*12  {user[4:0],cache[3:0],prot[2:0]}.
REQ-011 irq  out  1  level interrupt.

Function
REQ-012 Decode: ch = avs_address[9:6], reg = avs_address[5:2]; ch 0..C_NUM_CH-1 selects channel block, ch=4'hF selects global block; other ch read 0, writes ignored; avs_address[11:10] ignored.
REQ-013 Channel regs: 0 hps2ip_base, 1 hps2ip_ci_base, 2 hps2ip_mindex, 3 hps2ip_pi, 4 hps2ip_ci (RO), 7 cycle (RO), 8 ip2hps_base, 9 ip2hps_pi_base, A ip2hps_mindex, B ip2hps_pi (RO), C ip2hps_ci, E attr {4'h0,r_attr,4'h0,w_attr}, F ctrl {30'h0,irq_en,dma_en}; others read 0.
REQ-014 Base registers read {base,5'h0}; narrower fields zero-extended; writes take low bits (base takes [31:5]).
REQ-015 Global regs: 0 ID {16'hAC02, 8'h0, C_NUM_CH[7:0]} RO; 1 irq_status, write-1-to-clear; 2 irq_mask RW, low C_NUM_CH bits; others read 0.
REQ-016 Handshake: any cycle with avs_read or avs_write and no access in progress asserts avs_waitrequest combinationally for exactly 1 cycle; next cycle waitrequest=0 and access is accepted; each access therefore takes 2 cycles.
REQ-017 avs_read and avs_write both high: write performed, read ignored, no readdatavalid.
REQ-018 Read accepted in cycle N: avs_readdatavalid=1 with avs_readdata in cycle N+1 only; readdatavalid never asserted otherwise; avs_readdata holds last value otherwise.
REQ-019 Write accepted in cycle N: register updated at end of N, visible to a read accepted at N+2 or later.
REQ-020 cycle[n]: 32-bit, cleared while dma_en[n]=0, increments by 1 each cycle while 1, wraps 0xFFFFFFFF->0.
REQ-021 Interrupt source: ip2hps_pi[n] registered each cycle; when irq_en[n]=1 and ip2hps_pi[n] differs from its registered copy, irq_status[n] sets next cycle.
REQ-022 Set and W1C of same bit in same cycle: set wins (bit remains 1).
REQ-023 irq = |(irq_status & irq_mask), registered (1 cycle after status/mask change).
REQ-024 Clearing dma_en[n] does not clear irq_status[n]; clearing irq_en[n] blocks new sets only.
REQ-025 Channel-specific outputs of channel n change only by writes to channel n.

Reset
REQ-026 sys_rst=1 at a clock edge: all registers, outputs, irq_status, irq_mask, cycle counters, registered pi copies, readdatavalid, and in-progress access state cleared to 0 next cycle.
REQ-027 Reset during an access aborts it: no write, no readdatavalid; next request starts a new 2-cycle handshake.
REQ-028 Registered ip2hps_pi copy loads current input on first cycle after reset without setting irq_status.

Verification
REQ-029 Write 0x12345678 to ch1 reg0 (addr 0x040), read back -> readdata 0x12345660, waitrequest high 1 cycle per access, readdatavalid 1 cycle after accept.
REQ-030 C_NUM_CH=2: read ch5 reg0 and global reg0 -> 0x0 and 0xAC020002; write to ch5 changes no output.
REQ-031 ch0 ctrl=0x1 for 10 cycles then 0x0 -> cycle read reaches 9..10 range then reads 0 after disable.
REQ-032 ch0 ctrl=0x3, mask=0x1, ip2hps_pi[0] 0->5 -> irq_status=0x1, irq=1 two cycles after change; W1C 0x1 -> irq=0.
REQ-033 W1C to status in same cycle as new pi change -> status stays 1, irq stays 1.
REQ-034 Assert sys_rst during write waitrequest cycle -> target register 0, no readdatavalid, all outputs 0.
